// File: rtl/lfsr_seq_ctrl.sv
// Fibonacci LFSR with a seed/step sequencer: loads a seed, shifts a set number of times,
// streams each new state with a valid strobe. Optional period measurement under LFSR_PERIOD_EN.
module lfsr_seq_ctrl #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter int unsigned      CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             done,
`ifdef LFSR_PERIOD_EN
    output logic             err,
    output logic [CNT_W-1:0] period,
    output logic             period_vld
`else
    output logic             err
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_valid_q, q_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] q_next;
    logic             start_ok;

    assign q_next   = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    assign start_ok = (state_q == StIdle) && start && (seed != '0);

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        q_valid_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (seed != '0) begin
                        q_d     = seed;
                        cnt_d   = steps;
                        state_d = (steps != '0) ? StRun : StDone;
                    end else begin
                        // All-zero seed would lock the LFSR; refuse it.
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                q_d       = q_next;
                cnt_d     = cnt_q - CNT_W'(1);
                q_valid_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            q_q       <= '0;
            cnt_q     <= '0;
            q_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            q_valid_q <= q_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q == StRun) || (state_q == StDone);

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] period_q;
    logic             period_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q       <= '0;
            pcnt_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else if (start_ok) begin
            seed_q       <= seed;
            pcnt_q       <= '0;
            period_vld_q <= 1'b0;
        end else if (state_q == StRun) begin
            // Saturated counter means the period no longer fits; record nothing.
            if (pcnt_q != '1) begin
                pcnt_q <= pcnt_q + CNT_W'(1);
                if (!period_vld_q && (q_next == seed_q)) begin
                    period_q     <= pcnt_q + CNT_W'(1);
                    period_vld_q <= 1'b1;
                end
            end
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: expected LFSR states and done cycles are queued at
// each accepted start and checked as q_valid / done appear.
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] seed;
    logic [7:0] steps;
    logic [3:0] q;
    logic       q_valid;
    logic       busy;
    logic       done;
    logic       err;
`ifdef LFSR_PERIOD_EN
    logic [7:0] period;
    logic       period_vld;
    logic       exp_pv;
    int         exp_per;
`endif

    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    logic [3:0] q_exp[$];
    int         done_exp[$];

    lfsr_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .seed    (seed),
        .steps   (steps),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .done    (done),
`ifdef LFSR_PERIOD_EN
        .err        (err),
        .period     (period),
        .period_vld (period_vld)
`else
        .err     (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[2:0], ^(s & 4'b1100)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (q_valid) begin
                if (q_exp.size() == 0) check("q_valid_extra", {31'd0, q_valid}, 32'd0);
                else check("q_step", {28'd0, q}, {28'd0, q_exp.pop_front()});
            end
            if (done) begin
                if (done_exp.size() == 0) check("done_extra", {31'd0, done}, 32'd0);
                else check("done_cycle", cyc, done_exp.pop_front());
            end
        end
    end

    task automatic run_begin(input logic [3:0] s, input logic [7:0] n, output int t);
        logic [3:0] cur;
        @(posedge clk); #1;
        start = 1'b1; seed = s; steps = n;
        @(posedge clk); #1;
        start = 1'b0;
        t = cyc;
        cur = s;
`ifdef LFSR_PERIOD_EN
        exp_pv = 1'b0; exp_per = 0;
`endif
        for (int i = 1; i <= int'(n); i++) begin
            cur = nxt(cur);
            q_exp.push_back(cur);
`ifdef LFSR_PERIOD_EN
            if (!exp_pv && cur == s) begin exp_pv = 1'b1; exp_per = i; end
`endif
        end
        done_exp.push_back(t + int'(n) + 1);
        check("load_q", {28'd0, q}, {28'd0, s});
        check("load_qv", {31'd0, q_valid}, 32'd0);
        check("load_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_finish(input int t, input logic [7:0] n, input logic [3:0] fin);
        while (cyc < t + int'(n) + 2) @(posedge clk);
        #1;
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_q", {28'd0, q}, {28'd0, fin});
        check("q_queue_empty", q_exp.size(), 0);
        check("done_queue_empty", done_exp.size(), 0);
`ifdef LFSR_PERIOD_EN
        check("period_vld", {31'd0, period_vld}, {31'd0, exp_pv});
        if (exp_pv) check("period", {24'd0, period}, exp_per);
`endif
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; seed = '0; steps = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", {28'd0, q}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_qv", {31'd0, q_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
`ifdef LFSR_PERIOD_EN
        check("rst_pvld", {31'd0, period_vld}, 32'd0);
`endif
        rst = 1'b0;

        // Zero seed is rejected with a single err pulse.
        @(posedge clk); #1;
        start = 1'b1; seed = 4'b0000; steps = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_q", {28'd0, q}, 32'd0);
        @(posedge clk); #1;
        check("err_clear", {31'd0, err}, 32'd0);
        check("err_busy2", {31'd0, busy}, 32'd0);

        // Full period from seed 0001.
        run_begin(4'b0001, 8'd15, t);
        run_finish(t, 8'd15, 4'b0001);

        // Zero steps: load then straight to done, no q_valid.
        run_begin(4'b1010, 8'd0, t);
        run_finish(t, 8'd0, 4'b1010);

        // Start while busy is ignored.
        run_begin(4'b0001, 8'd8, t);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; seed = 4'b1111; steps = 8'd3;
        @(posedge clk); #1; start = 1'b0;
        run_finish(t, 8'd8, 4'b0101);

        // Reset mid-run.
        run_begin(4'b0001, 8'd10, t);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk);
        q_exp.delete();
        done_exp.delete();
        #1;
        check("midrst_q", {28'd0, q}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_qv", {31'd0, q_valid}, 32'd0);
        rst = 1'b0;
        run_begin(4'b0001, 8'd15, t);
        run_finish(t, 8'd15, 4'b0001);

        // Short run: no period match.
        run_begin(4'b0001, 8'd5, t);
        run_finish(t, 8'd5, 4'b0110);

        // Longer run with a random seed exercises the counter past one period.
        run_begin(4'($urandom_range(1, 15)), 8'd40, t);
        run_finish(t, 8'd40, q_exp.size() > 0 ? q_exp[$] : q);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
